// File: rtl/ahb_wr_snoop_fifo_if.sv
// rtl/ahb_wr_snoop_fifo_if.sv - snooped AHB-lite write signals and event stream bundle
interface ahb_wr_snoop_fifo_if #(
   parameter int LVL_W = 4
);
   logic             snoop_en;
   logic [1:0]       ahb_xx_htrans;
   logic             ahb_xx_hready;
   logic             ahb_xx_hwrite;
   logic [31:0]      ahb_xx_haddr;
   logic [2:0]       ahb_xx_hsize;
   logic [31:0]      ahb_xx_hwdata;
   logic             evt_vld;
   logic [31:0]      evt_addr;
   logic [31:0]      evt_data;
   logic [2:0]       evt_size;
   logic             evt_rdy;
   logic [LVL_W-1:0] level;
   logic             ovf;
   logic [15:0]      ovf_cnt;

   modport slave (
      input  snoop_en, ahb_xx_htrans, ahb_xx_hready, ahb_xx_hwrite,
             ahb_xx_haddr, ahb_xx_hsize, ahb_xx_hwdata, evt_rdy,
      output evt_vld, evt_addr, evt_data, evt_size, level, ovf, ovf_cnt
   );

   modport master (
      output snoop_en, ahb_xx_htrans, ahb_xx_hready, ahb_xx_hwrite,
             ahb_xx_haddr, ahb_xx_hsize, ahb_xx_hwdata, evt_rdy,
      input  evt_vld, evt_addr, evt_data, evt_size, level, ovf, ovf_cnt
   );
endinterface

// File: rtl/ahb_wr_snoop_fifo.sv
// rtl/ahb_wr_snoop_fifo.sv - passive AHB-lite write snooper feeding a FWFT event FIFO
module ahb_wr_snoop_fifo #(
   parameter logic [31:0] ADDR_LO = 32'h2000_7c50,
   parameter logic [31:0] ADDR_HI = 32'h2000_7c9c,
   parameter int          DEPTH   = 8,
   parameter int          LVL_W   = 4
) (
   input  logic              sysclk,
   input  logic              sysrst,
   ahb_wr_snoop_fifo_if.slave bus
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic              pend_vld;
   logic [31:0]       pend_addr;
   logic [2:0]        pend_size;

   logic [31:0]       mem_addr [DEPTH];
   logic [31:0]       mem_data [DEPTH];
   logic [2:0]        mem_size [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [LVL_W-1:0]  count;
   logic              ovf_r;
   logic [15:0]       ovf_cnt_r;

   logic addr_qual, push, pop, full, empty, push_ok, drop;

   assign addr_qual = bus.ahb_xx_hready
                    & (bus.ahb_xx_htrans inside {2'b10, 2'b11})
                    & bus.ahb_xx_hwrite
                    & bus.snoop_en
                    & (bus.ahb_xx_haddr >= ADDR_LO)
                    & (bus.ahb_xx_haddr <= ADDR_HI);

   // A data phase completes on the first hready edge after its address phase.
   assign push    = pend_vld & bus.ahb_xx_hready;
   assign empty   = (count == '0);
   assign full    = (count == LVL_W'(DEPTH));
   assign pop     = ~empty & bus.evt_rdy;
   assign push_ok = push & (~full | pop);
   assign drop    = push & full & ~pop;

   always_ff @(posedge sysclk) begin
      if (sysrst) begin
         pend_vld  <= 1'b0;
         pend_addr <= '0;
         pend_size <= '0;
      end else if (bus.ahb_xx_hready) begin
         pend_vld <= addr_qual;
         if (addr_qual) begin
            pend_addr <= bus.ahb_xx_haddr;
            pend_size <= bus.ahb_xx_hsize;
         end
      end
   end

   always_ff @(posedge sysclk) begin
      if (push_ok) begin
         mem_addr[wr_ptr] <= pend_addr;
         mem_data[wr_ptr] <= bus.ahb_xx_hwdata;
         mem_size[wr_ptr] <= pend_size;
      end
   end

   always_ff @(posedge sysclk) begin
      if (sysrst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         ovf_r     <= 1'b0;
         ovf_cnt_r <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + LVL_W'(1);
            2'b01:   count <= count - LVL_W'(1);
            default: count <= count;
         endcase
         if (drop) begin
            ovf_r <= 1'b1;
            if (ovf_cnt_r != 16'hffff) ovf_cnt_r <= ovf_cnt_r + 16'd1;
         end
      end
   end

   assign bus.evt_vld  = ~empty;
   assign bus.evt_addr = empty ? '0 : mem_addr[rd_ptr];
   assign bus.evt_data = empty ? '0 : mem_data[rd_ptr];
   assign bus.evt_size = empty ? '0 : mem_size[rd_ptr];
   assign bus.level    = count;
   assign bus.ovf      = ovf_r;
   assign bus.ovf_cnt  = ovf_cnt_r;
endmodule

// File: tb/tb_ahb_wr_snoop_fifo.sv
// tb/tb_ahb_wr_snoop_fifo.sv - directed vector bench for ahb_wr_snoop_fifo
module tb_ahb_wr_snoop_fifo;
   logic sysclk = 1'b0;
   logic sysrst;
   always #5 sysclk = ~sysclk;

   ahb_wr_snoop_fifo_if #(.LVL_W(4)) bus ();

   ahb_wr_snoop_fifo #(
      .ADDR_LO(32'h2000_7c50), .ADDR_HI(32'h2000_7c9c), .DEPTH(8), .LVL_W(4)
   ) dut (
      .sysclk(sysclk),
      .sysrst(sysrst),
      .bus(bus.slave)
   );

   typedef struct {
      logic        en;
      logic [1:0]  tr;
      logic        wr;
      logic        hr;
      logic [31:0] a;
      logic [2:0]  sz;
      logic [31:0] d;
      logic        er;
      logic        ev;
      logic [31:0] ea;
      logic [31:0] ed;
      logic [2:0]  es;
      logic [3:0]  lvl;
   } vec_t;

   localparam int NV = 22;
   vec_t tbl [NV];
   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] exp_a [16];
   logic [31:0] exp_d [16];
   int k;

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drv(input logic en, input logic [1:0] tr, input logic wr, input logic hr,
                      input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d,
                      input logic er);
      bus.snoop_en      = en;
      bus.ahb_xx_htrans = tr;
      bus.ahb_xx_hwrite = wr;
      bus.ahb_xx_hready = hr;
      bus.ahb_xx_haddr  = a;
      bus.ahb_xx_hsize  = sz;
      bus.ahb_xx_hwdata = d;
      bus.evt_rdy       = er;
   endtask

   task automatic step();
      @(posedge sysclk);
      #1;
   endtask

   task automatic idle(input logic [31:0] d, input logic er);
      drv(1'b1, 2'b00, 1'b0, 1'b1, 32'h0, 3'd0, d, er);
   endtask

   task automatic wr(input logic en, input logic [1:0] tr, input logic [31:0] a,
                     input logic [2:0] sz, input logic [31:0] d, input logic er);
      drv(en, tr, 1'b1, 1'b1, a, sz, d, er);
   endtask

   task automatic mon_burst();
      if (bus.evt_vld) begin
         if (k < 16) chk("burst_evt", {32'h0, bus.evt_addr, bus.evt_data}, {32'h0, exp_a[k], exp_d[k]});
         k++;
      end
   endtask

   initial begin
      //            en  tr     wr  hr  addr          sz  data          er   ev  eaddr         edata         es  lvl
      tbl[0]  = '{1'b1,2'b10,1'b1,1'b1,32'h2000_7c50,3'd2,32'h0,        1'b0,1'b0,32'h0,        32'h0,     3'd0,4'd0};
      tbl[1]  = '{1'b1,2'b00,1'b0,1'b1,32'h0,        3'd0,32'h2002,     1'b0,1'b1,32'h2000_7c50,32'h2002,  3'd2,4'd1};
      tbl[2]  = '{1'b1,2'b00,1'b0,1'b1,32'h0,        3'd0,32'h0,        1'b1,1'b0,32'h0,        32'h0,     3'd0,4'd0};
      tbl[3]  = '{1'b1,2'b10,1'b1,1'b1,32'h2000_7c50,3'd2,32'h0,        1'b0,1'b0,32'h0,        32'h0,     3'd0,4'd0};
      tbl[4]  = '{1'b1,2'b00,1'b0,1'b0,32'h0,        3'd0,32'h11,       1'b0,1'b0,32'h0,        32'h0,     3'd0,4'd0};
      tbl[5]  = '{1'b1,2'b00,1'b0,1'b0,32'h0,        3'd0,32'h22,       1'b0,1'b0,32'h0,        32'h0,     3'd0,4'd0};
      tbl[6]  = '{1'b1,2'b00,1'b0,1'b0,32'h0,        3'd0,32'h33,       1'b0,1'b0,32'h0,        32'h0,     3'd0,4'd0};
      tbl[7]  = '{1'b1,2'b00,1'b0,1'b1,32'h0,        3'd0,32'h41,       1'b0,1'b1,32'h2000_7c50,32'h41,    3'd2,4'd1};
      tbl[8]  = '{1'b1,2'b00,1'b0,1'b1,32'h0,        3'd0,32'h0,        1'b1,1'b0,32'h0,        32'h0,     3'd0,4'd0};
      tbl[9]  = '{1'b1,2'b10,1'b0,1'b1,32'h2000_7c50,3'd2,32'h0,        1'b0,1'b0,32'h0,        32'h0,     3'd0,4'd0};
      tbl[10] = '{1'b1,2'b00,1'b0,1'b1,32'h0,        3'd0,32'hdead,     1'b0,1'b0,32'h0,        32'h0,     3'd0,4'd0};
      tbl[11] = '{1'b1,2'b10,1'b1,1'b1,32'h2000_7ca0,3'd2,32'h0,        1'b0,1'b0,32'h0,        32'h0,     3'd0,4'd0};
      tbl[12] = '{1'b1,2'b00,1'b0,1'b1,32'h0,        3'd0,32'hbeef,     1'b0,1'b0,32'h0,        32'h0,     3'd0,4'd0};
      tbl[13] = '{1'b1,2'b01,1'b1,1'b1,32'h2000_7c54,3'd2,32'h0,        1'b0,1'b0,32'h0,        32'h0,     3'd0,4'd0};
      tbl[14] = '{1'b1,2'b00,1'b0,1'b1,32'h0,        3'd0,32'h1234,     1'b0,1'b0,32'h0,        32'h0,     3'd0,4'd0};
      tbl[15] = '{1'b1,2'b10,1'b1,1'b1,32'h2000_7c4c,3'd2,32'h0,        1'b0,1'b0,32'h0,        32'h0,     3'd0,4'd0};
      tbl[16] = '{1'b1,2'b00,1'b0,1'b1,32'h0,        3'd0,32'h4c4c,     1'b0,1'b0,32'h0,        32'h0,     3'd0,4'd0};
      tbl[17] = '{1'b1,2'b10,1'b1,1'b1,32'h2000_7c9c,3'd0,32'h0,        1'b0,1'b0,32'h0,        32'h0,     3'd0,4'd0};
      tbl[18] = '{1'b1,2'b00,1'b0,1'b1,32'h0,        3'd0,32'h9c,       1'b0,1'b1,32'h2000_7c9c,32'h9c,    3'd0,4'd1};
      tbl[19] = '{1'b1,2'b00,1'b0,1'b1,32'h0,        3'd0,32'h0,        1'b1,1'b0,32'h0,        32'h0,     3'd0,4'd0};
      tbl[20] = '{1'b0,2'b10,1'b1,1'b1,32'h2000_7c50,3'd2,32'h0,        1'b0,1'b0,32'h0,        32'h0,     3'd0,4'd0};
      tbl[21] = '{1'b1,2'b00,1'b0,1'b1,32'h0,        3'd0,32'h5050,     1'b0,1'b0,32'h0,        32'h0,     3'd0,4'd0};

      for (int i = 0; i < 16; i++) begin
         exp_a[i] = 32'h2000_7c60 + 32'(4 * i);
         exp_d[i] = 32'ha500_0000 | 32'(i);
      end

      // reset state
      sysrst = 1'b1;
      idle(32'h0, 1'b0);
      step();
      step();
      chk("reset_out", {bus.evt_vld, bus.evt_addr, bus.evt_data, bus.evt_size, bus.level, bus.ovf, bus.ovf_cnt},
          {1'b0, 32'h0, 32'h0, 3'd0, 4'd0, 1'b0, 16'h0});
      sysrst = 1'b0;

      // table vectors: single write, wait states, filtered phases, window edges
      for (int i = 0; i < NV; i++) begin
         drv(tbl[i].en, tbl[i].tr, tbl[i].wr, tbl[i].hr, tbl[i].a, tbl[i].sz, tbl[i].d, tbl[i].er);
         step();
         chk($sformatf("vec%0d", i), {bus.evt_vld, bus.evt_addr, bus.evt_data, bus.evt_size, bus.level},
             {tbl[i].ev, tbl[i].ea, tbl[i].ed, tbl[i].es, tbl[i].lvl});
      end

      // pipelined 16-beat burst with a BUSY cycle in the middle
      k = 0;
      for (int i = 0; i < 16; i++) begin
         if (i == 8) begin
            wr(1'b1, 2'b01, exp_a[8], 3'd2, exp_d[7], 1'b1);
            step();
            mon_burst();
         end
         wr(1'b1, (i == 0) ? 2'b10 : 2'b11, exp_a[i], 3'd2,
            (i == 0 || i == 8) ? 32'h0 : exp_d[i-1], 1'b1);
         step();
         mon_burst();
      end
      idle(exp_d[15], 1'b1);
      step();
      mon_burst();
      for (int i = 0; i < 3; i++) begin
         idle(32'h0, 1'b1);
         step();
         mon_burst();
      end
      chk("burst_count", 96'(k), 96'd16);
      drv(1'b1, 2'b10, 1'b0, 1'b1, 32'h2000_7c70, 3'd2, 32'h0, 1'b1);
      step();
      idle(32'h7777, 1'b1);
      step();
      wr(1'b1, 2'b10, 32'h2000_7ca0, 3'd2, 32'h0, 1'b1);
      step();
      idle(32'h8888, 1'b1);
      step();
      chk("post_burst_empty", {bus.evt_vld, bus.level}, {1'b0, 4'd0});

      // overflow: 10 writes into 8 entries with the consumer stalled
      for (int i = 0; i < 10; i++) begin
         wr(1'b1, 2'b10, 32'h2000_7c50 + 32'(4 * i), 3'd2,
            (i == 0) ? 32'h0 : 32'h100 + 32'(i - 1), 1'b0);
         step();
      end
      idle(32'h109, 1'b0);
      step();
      chk("ovf_state", {bus.level, bus.ovf, bus.ovf_cnt}, {4'd8, 1'b1, 16'd2});
      chk("ovf_head", {bus.evt_addr, bus.evt_data, bus.evt_size}, {32'h2000_7c50, 32'h100, 3'd2});
      wr(1'b1, 2'b10, 32'h2000_7c78, 3'd2, 32'h0, 1'b0);
      step();
      idle(32'h1aa, 1'b1);
      step();
      chk("full_push_pop", {bus.level, bus.ovf, bus.ovf_cnt}, {4'd8, 1'b1, 16'd2});
      idle(32'h0, 1'b0);
      step();
      chk("head_stable", {bus.evt_vld, bus.evt_addr, bus.evt_data}, {1'b1, 32'h2000_7c54, 32'h101});

      // reset between address and data phase
      wr(1'b1, 2'b10, 32'h2000_7c60, 3'd2, 32'h0, 1'b0);
      step();
      sysrst = 1'b1;
      idle(32'h55, 1'b0);
      step();
      chk("mid_reset", {bus.evt_vld, bus.evt_addr, bus.evt_data, bus.evt_size, bus.level, bus.ovf, bus.ovf_cnt},
          {1'b0, 32'h0, 32'h0, 3'd0, 4'd0, 1'b0, 16'h0});
      sysrst = 1'b0;
      idle(32'h66, 1'b0);
      step();
      chk("after_reset_drop", {bus.evt_vld, bus.level}, {1'b0, 4'd0});
      wr(1'b1, 2'b10, 32'h2000_7c64, 3'd1, 32'h0, 1'b0);
      step();
      idle(32'h77, 1'b0);
      step();
      chk("after_reset_wr", {bus.evt_vld, bus.evt_addr, bus.evt_data, bus.evt_size, bus.level},
          {1'b1, 32'h2000_7c64, 32'h77, 3'd1, 4'd1});
      idle(32'h0, 1'b1);
      step();

      // snoop_en dropped while a data phase is pending
      wr(1'b1, 2'b10, 32'h2000_7c68, 3'd2, 32'h0, 1'b0);
      step();
      wr(1'b0, 2'b10, 32'h2000_7c6c, 3'd2, 32'h88, 1'b0);
      step();
      chk("en_drop_pending", {bus.evt_vld, bus.evt_addr, bus.evt_data, bus.level},
          {1'b1, 32'h2000_7c68, 32'h88, 4'd1});
      drv(1'b0, 2'b00, 1'b0, 1'b1, 32'h0, 3'd0, 32'h99, 1'b0);
      step();
      wr(1'b0, 2'b10, 32'h2000_7c70, 3'd2, 32'h0, 1'b0);
      step();
      drv(1'b0, 2'b00, 1'b0, 1'b1, 32'h0, 3'd0, 32'h9a, 1'b0);
      step();
      chk("en_off_ignored", 96'(bus.level), 96'd1);
      wr(1'b1, 2'b10, 32'h2000_7c74, 3'd2, 32'h0, 1'b0);
      step();
      idle(32'haa, 1'b0);
      step();
      chk("en_back_on", 96'(bus.level), 96'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ahb_wr_snoop_fifo.md
Name: ahb_wr_snoop_fifo

Overview:
- Passive AHB-lite write snooper that feeds the bus monitor stage.
- Pairs each qualifying address phase with its data phase, including wait states.
- Buffers complete write events {addr, data, size} in a first-word-fall-through FIFO, so the downstream monitor/console logic consumes one clean event per write through a valid/ready handshake.
- Never drives the bus.

Parameters:
- ADDR_LO, 32'h20007c50, lowest captured byte address (inclusive).
- ADDR_HI, 32'h20007c9c, highest captured byte address (inclusive).
- DEPTH, 8, FIFO entries; power of two, >= 2.
- LVL_W, 4, width of level output; must be >= clog2(DEPTH+1).

Ports:
- sysclk  in  1  clock; all state on rising edge.
- sysrst  in  1  reset, synchronous, active-high.
- snoop_en  in  1  1 = accept new address phases.
- ahb_xx_htrans  in  2  snooped HTRANS.
- ahb_xx_hready  in  1  snooped HREADY.
- ahb_xx_hwrite  in  1  snooped HWRITE.
- ahb_xx_haddr  in  32  snooped HADDR.
- ahb_xx_hsize  in  3  snooped HSIZE.
- ahb_xx_hwdata  in  32  snooped HWDATA.
- evt_vld  out  1  FIFO head valid.
- evt_addr  out  32  head address.
- evt_data  out  32  head write data.
- evt_size  out  3  head HSIZE.
- evt_rdy  in  1  consumer pops head when evt_vld & evt_rdy.
- level  out  LVL_W  current FIFO occupancy.
- ovf  out  1  sticky: at least one event was dropped.
- ovf_cnt  out  16  dropped-event count, saturating at 16'hffff.

Behaviour:
- Reset (sysrst=1 at an edge):
  - Clears the pending-phase register, FIFO pointers and count, ovf and ovf_cnt.
  - Outputs after reset: evt_vld=0, level=0, ovf=0, ovf_cnt=0, evt_addr/evt_data/evt_size=0.
  - A data phase in flight when reset is asserted is discarded.
- Address phase accept (edge with all of the following true):
  - ahb_xx_hready=1, ahb_xx_htrans[1]=1 (NONSEQ 2'b10 or SEQ 2'b11), ahb_xx_hwrite=1, snoop_en=1, ADDR_LO <= haddr <= ADDR_HI (unsigned).
  - On accept: pend_vld<=1, pend_addr<=haddr, pend_size<=hsize.
  - IDLE, BUSY, reads and out-of-window addresses leave no state.
- Data phase completion:
  - The first edge after acceptance with ahb_xx_hready=1 and pend_vld=1 completes the data phase.
  - At that edge, push {pend_addr, ahb_xx_hwdata, pend_size}.
  - At that same edge, pend_vld is reloaded from the current address-phase qualification; back-to-back pipelined writes are each captured.
  - While hready=0, pend_* hold and no address phase is sampled.
- snoop_en deassertion does not cancel a pending data phase; that phase still completes and pushes.
- Latency: with zero wait states, address phase at edge N, push at edge N+1, evt_vld=1 in the cycle after edge N+1. Each wait state adds one cycle.
- FIFO:
  - First-word-fall-through; evt_* show the head combinationally from the storage array, and are 0 when empty.
  - Pop and push in the same cycle are both performed.
  - When full with no pop, a push is dropped: ovf<=1, ovf_cnt increments and saturates.
  - When full with a simultaneous pop, the push is accepted and level stays DEPTH.
  - Pop when empty is ignored.
  - Pointers wrap modulo DEPTH.
  - level = count, range 0..DEPTH.
- evt_* stay stable while evt_vld=1 and evt_rdy=0.
- ovf and ovf_cnt clear only on reset.

Test Plan:
- Single write, haddr=0x20007c50, hwdata=0x2002, hsize=2, no waits -> evt_vld rises 2 cycles after the address phase with addr=0x20007c50, data=0x2002, size=2; level=1; one pop -> level=0, evt_vld=0.
- Write to 0x20007c50 with 3 hready=0 wait cycles, hwdata changes each wait cycle, final value 0x41 -> exactly one event, data=0x41, visible after the edge where hready returns to 1.
- Pipelined writes NONSEQ 0x20007c60, then SEQ 0x20007c64..0x20007c9c (16 beats), evt_rdy=1 -> 16 events in order with correct address/data pairing; BUSY inserted mid-burst creates no event; a read and a write to 0x20007ca0 create no event.
- DEPTH=8, evt_rdy=0, 10 writes -> level=8, ovf=1, ovf_cnt=2, head still the first write; then a push and a pop in the same cycle while full -> level stays 8, ovf_cnt unchanged.
- sysrst pulsed one cycle after a write address phase, before its data phase -> no event, all outputs 0; the next write after reset is captured normally.
- snoop_en dropped in the cycle after an accepted address phase -> that write still produces an event; subsequent writes produce none until snoop_en=1.
